crc32: RTL and testbench

CRC32 -- requirements
Module: crc32

---
 rtl/crc32.sv | 51 +++++
 tb/tb_crc32.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/crc32.sv
// Byte-wide IEEE 802.3 / zlib CRC-32 generator, one byte absorbed per clock.
// Define CRC32_CHECK_EN to add the rx_crc_ok residue flag.
module crc32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_we,
  input  logic [7:0]  rx_byte,
  output logic [31:0] tx_crc
`ifdef CRC32_CHECK_EN
  ,
  output logic        rx_crc_ok
`endif
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  logic [31:0] r_crc_q;
  logic [7:0]  w_byte;
  logic [31:0] w_crc_next;

  // Gate the byte so an undriven bus cannot leak into the update network.
  assign w_byte = rx_byte & {8{rx_we}};

  // Eight unrolled shift steps collapse into a single-cycle XOR network.
  always_comb begin
    logic [31:0] c;
    c = r_crc_q ^ {24'b0, w_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
    end
    w_crc_next = c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc_q <= CRC_INIT;
    end else if (rx_we) begin
      r_crc_q <= w_crc_next;
    end
  end

  assign tx_crc = ~r_crc_q;

`ifdef CRC32_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  assign rx_crc_ok = (r_crc_q == CRC_RESIDUE);
`endif

endmodule

// File: tb/tb_crc32.sv
// Scoreboard bench for crc32: table-driven reference model over the absorbed frame.
// Honours CRC32_CHECK_EN to also check rx_crc_ok.
module tb_crc32;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_we;
  logic [7:0]  rx_byte;
  logic [31:0] tx_crc;
`ifdef CRC32_CHECK_EN
  logic        rx_crc_ok;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] crc_tbl[256];
  byte_q_t     frame;
  exp_t        exp_q[$];

  crc32 dut (
    .clk      (clk),
    .reset    (reset),
    .rx_we    (rx_we),
    .rx_byte  (rx_byte),
    .tx_crc   (tx_crc)
`ifdef CRC32_CHECK_EN
    ,
    .rx_crc_ok(rx_crc_ok)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_crc(input byte_q_t q);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) c = (c >> 8) ^ crc_tbl[(c[7:0] ^ q[i])];
    return ~c;
  endfunction

  // One clock of stimulus; the expected post-edge response goes to the scoreboard.
  task automatic step(input logic rst, input logic we, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    rx_we   = we;
    rx_byte = b;
    if (rst) frame.delete();
    else if (we) frame.push_back(b);
    e.crc = model_crc(frame);
    e.ok  = (e.crc == 32'h2144DF1C);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic send_seq(input byte_q_t s, input bit gaps);
    foreach (s[i]) begin
      step(1'b0, 1'b1, s[i]);
      if (gaps) repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 8'($urandom));
    end
  endtask

  task automatic expect_tx(input string name, input logic [31:0] want);
    #2;
    checks++;
    if (tx_crc !== want) begin
      errors++;
      $display("FAIL %s: tx_crc=%08h expected %08h", name, tx_crc, want);
    end
  endtask

`ifdef CRC32_CHECK_EN
  task automatic expect_ok(input string name, input logic want);
    checks++;
    if (rx_crc_ok !== want) begin
      errors++;
      $display("FAIL %s: rx_crc_ok=%0b expected %0b", name, rx_crc_ok, want);
    end
  endtask
`endif

  // Monitor: every clock after a stimulus step, compare DUT against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (tx_crc !== e.crc) begin
          errors++;
          $display("FAIL scoreboard tx_crc: got %08h expected %08h at %0t", tx_crc, e.crc, $time);
        end
`ifdef CRC32_CHECK_EN
        checks++;
        if (rx_crc_ok !== e.ok) begin
          errors++;
          $display("FAIL scoreboard rx_crc_ok: got %0b expected %0b at %0t", rx_crc_ok, e.ok, $time);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    byte_q_t digits, resid, zeros4, rnd;
    logic [31:0] c;
    int n;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end
    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zeros4 = '{8'h00, 8'h00, 8'h00, 8'h00};
    resid  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};

    reset = 1'b1; rx_we = 1'b0; rx_byte = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    expect_tx("reset_state", 32'h00000000);
`ifdef CRC32_CHECK_EN
    expect_ok("reset_ok", 1'b0);
`endif
    repeat (3) step(1'b0, 1'b0, 8'($urandom));
    expect_tx("idle_no_writes", 32'h00000000);

    step(1'b0, 1'b1, 8'h00);
    expect_tx("single_00", 32'hD202EF8D);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    expect_tx("single_FF", 32'hFF000000);

    step(1'b1, 1'b0, 8'h00);
    send_seq(digits, 1'b0);
    expect_tx("digits_b2b", 32'hCBF43926);

    step(1'b1, 1'b0, 8'h00);
    send_seq(zeros4, 1'b0);
    expect_tx("four_zeros", 32'h2144DF1C);
`ifdef CRC32_CHECK_EN
    expect_ok("four_zeros_ok", 1'b1);
`endif

    step(1'b1, 1'b0, 8'h00);
    send_seq(resid, 1'b0);
    expect_tx("digits_residue", 32'h2144DF1C);
`ifdef CRC32_CHECK_EN
    expect_ok("digits_residue_ok", 1'b1);
`endif

    step(1'b1, 1'b0, 8'h00);
    send_seq(digits, 1'b1);
    expect_tx("digits_gaps", 32'hCBF43926);

    step(1'b1, 1'b0, 8'h00);
    send_seq(zeros4, 1'b0);
    step(1'b1, 1'b1, 8'hA5);
    expect_tx("reset_with_we", 32'h00000000);
    send_seq(digits, 1'b0);
    expect_tx("digits_after_reset", 32'hCBF43926);

    // Random frames with gaps, occasional mid-frame resets and self-CRC trailers.
    for (int f = 0; f < 40; f++) begin
      step(1'b1, ($urandom_range(0, 1) == 1), 8'($urandom));
      n = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 8'($urandom));
        if ($urandom_range(0, 60) == 0) step(1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b1, 8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        c = model_crc(frame);
        rnd = '{c[7:0], c[15:8], c[23:16], c[31:24]};
        send_seq(rnd, ($urandom_range(0, 1) == 1));
        expect_tx("random_residue", 32'h2144DF1C);
      end
    end

    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
